// File: rtl/cpu_mem_pkg.sv
// -----------------------------------------------------------------------------
// cpu_mem_pkg
//   Shared definitions for the CPU memory path: memory-mapped IO addresses,
//   the bus arbiter state encoding and the grant encoding.
// -----------------------------------------------------------------------------
package cpu_mem_pkg;

    // Memory-mapped IO addresses
    localparam logic [31:0] UART_DATA_ADDR = 32'hBFD0_03F8;
    localparam logic [31:0] UART_STAT_ADDR = 32'hBFD0_03FC;
    localparam logic [31:0] LED_ADDR       = 32'hBFD0_0400;
    localparam logic [31:0] DPY_ADDR       = 32'hBFD0_0408;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Which requester currently owns the MMU port
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single MMU port between instruction fetch and the data-memory
//   stage. The data port has priority, but after MAX_DATA_STREAK consecutive
//   data grants with a fetch waiting, the fetch is forced through. MMU strobes
//   are held for WAIT_CYCLES+1 cycles, read data is captured into a per-port
//   register, and a one-cycle ready pulse goes back to the granted requester.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   if_req / if_addr    fetch request (word read), held until if_ready
//   if_ready / if_rdata one-cycle done pulse, registered fetch data
//   mem_req, mem_we, mem_byte, mem_addr, mem_wdata
//                       data request and qualifiers, held until mem_ready
//   mem_ready/mem_rdata one-cycle done pulse, registered load data
//   stall               high while any request is outstanding
//   mmu_read/mmu_write/mmu_addr/mmu_wdata/mmu_bytemode
//                       registered strobes and fields towards the MMU
//   mmu_rdata           read data returned by the MMU
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES     = 1,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic [31:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,

    output logic        stall,

    output logic        mmu_read,
    output logic        mmu_write,
    output logic [31:0] mmu_addr,
    output logic [31:0] mmu_wdata,
    output logic        mmu_bytemode,
    input  logic [31:0] mmu_rdata
);

    localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    arb_state_t  state_q,    state_d;
    grant_t      grant_q,    grant_d;
    logic [3:0]  wait_q,     wait_d;
    logic [3:0]  streak_q,   streak_d;

    logic        read_d,     write_d,  bytemode_d;
    logic [31:0] addr_d,     wdata_d;
    logic        if_ready_d, mem_ready_d;
    logic [31:0] if_rdata_d, mem_rdata_d;

    logic        take_mem;
    logic [31:0] sel_addr;

    // Data wins unless a fetch is waiting and the data streak is exhausted.
    assign take_mem = mem_req && !(if_req && (streak_q == STREAK_MAX));
    assign sel_addr = take_mem ? mem_addr : if_addr;

    assign stall = (if_req & ~if_ready) | (mem_req & ~mem_ready);

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            wait_q       <= '0;
            streak_q     <= '0;
            mmu_read     <= 1'b0;
            mmu_write    <= 1'b0;
            mmu_addr     <= '0;
            mmu_wdata    <= '0;
            mmu_bytemode <= 1'b0;
            if_ready     <= 1'b0;
            mem_ready    <= 1'b0;
            if_rdata     <= '0;
            mem_rdata    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            wait_q       <= wait_d;
            streak_q     <= streak_d;
            mmu_read     <= read_d;
            mmu_write    <= write_d;
            mmu_addr     <= addr_d;
            mmu_wdata    <= wdata_d;
            mmu_bytemode <= bytemode_d;
            if_ready     <= if_ready_d;
            mem_ready    <= mem_ready_d;
            if_rdata     <= if_rdata_d;
            mem_rdata    <= mem_rdata_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        read_d      = mmu_read;
        write_d     = mmu_write;
        addr_d      = mmu_addr;
        wdata_d     = mmu_wdata;
        bytemode_d  = mmu_bytemode;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        if_rdata_d  = if_rdata;
        mem_rdata_d = mem_rdata;

        unique case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_d = ACCESS;
                    addr_d  = sel_addr;
                    // A UART data read pops the RX FIFO, so it must see exactly
                    // one strobe cycle whatever the configured wait.
                    wait_d  = (sel_addr == UART_DATA_ADDR) ? '0 : WAIT_INIT;
                    if (take_mem) begin
                        grant_d    = GNT_MEM;
                        read_d     = ~mem_we;
                        write_d    = mem_we;
                        wdata_d    = mem_wdata;
                        bytemode_d = mem_byte;
                        if (if_req) begin
                            streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
                        end else begin
                            streak_d = '0;
                        end
                    end else begin
                        grant_d    = GNT_IF;
                        read_d     = 1'b1;
                        write_d    = 1'b0;
                        bytemode_d = 1'b0;
                        streak_d   = '0;
                    end
                end
            end

            ACCESS: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    if (mmu_read) begin
                        if (grant_q == GNT_IF) begin
                            if_rdata_d = mmu_rdata;
                        end else begin
                            mem_rdata_d = mmu_rdata;
                        end
                    end
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (grant_q == GNT_IF) begin
                        if_ready_d = 1'b1;
                    end else begin
                        mem_ready_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Self-checking bench for mem_bus_arbiter. A transaction-timeline model
//   predicts, for every cycle, strobes, ready pulses, captured data and stall.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    import cpu_mem_pkg::*;

    localparam int unsigned W    = 3;
    localparam int unsigned MAXS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_byte = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        mmu_read;
    logic        mmu_write;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_wdata;
    logic        mmu_bytemode;
    logic [31:0] mmu_rdata;

    mem_bus_arbiter #(
        .WAIT_CYCLES    (W),
        .MAX_DATA_STREAK(MAXS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_ready    (if_ready),
        .if_rdata    (if_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_byte    (mem_byte),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .stall       (stall),
        .mmu_read    (mmu_read),
        .mmu_write   (mmu_write),
        .mmu_addr    (mmu_addr),
        .mmu_wdata   (mmu_wdata),
        .mmu_bytemode(mmu_bytemode),
        .mmu_rdata   (mmu_rdata)
    );

    always #5 clk = ~clk;

    // Memory contents seen through the MMU
    function automatic logic [31:0] mmu_fn(input logic [31:0] a);
        if (a == 32'h8000_0004) return 32'h3C08_DEAD;
        if (a == UART_DATA_ADDR) return 32'h0000_0041;
        return {a[15:0] ^ 16'hA5C3, a[31:16] + 16'h1357};
    endfunction

    assign mmu_rdata = mmu_fn(mmu_addr);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model: one access as a timeline ----------------
    // An access granted at edge N strobes for L cycles, pulses ready in the
    // cycle after edge N+L, and the port is free to grant again at edge N+L+2.
    bit          m_active;
    bit          m_if;
    bit          m_we;
    bit          m_byte;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    int          m_k;
    int          m_len;
    int          m_streak;
    logic [31:0] m_if_rdata;
    logic [31:0] m_mem_rdata;

    bit e_if_rdy, e_mem_rdy;
    bit mem_auto  = 1'b0;
    bit rand_mode = 1'b0;
    bit saw_if_rdy;
    int cyc_no = 0;
    int t_if_rdy, t_mem_rdy;
    int obs_read_cyc, obs_write_cyc, obs_sb_cyc, obs_mem_rdy, obs_if_rdy;

    task automatic model_reset();
        m_active    = 1'b0;
        m_streak    = 0;
        m_if_rdata  = '0;
        m_mem_rdata = '0;
    endtask

    task automatic model_edge();
        bit data;
        if (m_active) begin
            m_k++;
            if (m_k == m_len && !m_we) begin
                if (m_if) m_if_rdata = mmu_fn(m_addr);
                else      m_mem_rdata = mmu_fn(m_addr);
            end
            if (m_k > m_len) m_active = 1'b0;
        end else if (if_req || mem_req) begin
            data = mem_req && !(if_req && m_streak == int'(MAXS));
            if (data) begin
                m_if     = 1'b0;
                m_we     = mem_we;
                m_byte   = mem_byte;
                m_addr   = mem_addr;
                m_wdata  = mem_wdata;
                m_streak = if_req ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
            end else begin
                m_if     = 1'b1;
                m_we     = 1'b0;
                m_byte   = 1'b0;
                m_addr   = if_addr;
                m_streak = 0;
            end
            m_len    = (m_addr == UART_DATA_ADDR) ? 1 : int'(W) + 1;
            m_k      = 0;
            m_active = 1'b1;
        end
    endtask

    task automatic compare();
        bit strobing;
        strobing  = m_active && (m_k < m_len);
        e_if_rdy  = m_active && (m_k == m_len) && m_if;
        e_mem_rdy = m_active && (m_k == m_len) && !m_if;
        check_eq("mmu_read",  32'(mmu_read),  32'(strobing && !m_we));
        check_eq("mmu_write", 32'(mmu_write), 32'(strobing && m_we));
        check_eq("if_ready",  32'(if_ready),  32'(e_if_rdy));
        check_eq("mem_ready", 32'(mem_ready), 32'(e_mem_rdy));
        check_eq("if_rdata",  if_rdata,  m_if_rdata);
        check_eq("mem_rdata", mem_rdata, m_mem_rdata);
        check_eq("stall", 32'(stall),
                 32'((if_req && !e_if_rdy) || (mem_req && !e_mem_rdy)));
        if (strobing) begin
            check_eq("mmu_addr",     mmu_addr, m_addr);
            check_eq("mmu_bytemode", 32'(mmu_bytemode), 32'(m_byte));
            if (m_we) check_eq("mmu_wdata", mmu_wdata, m_wdata);
        end
        if (mmu_read)  obs_read_cyc++;
        if (mmu_write) obs_write_cyc++;
        if (mmu_write && mmu_bytemode && mmu_wdata == 32'hAB) obs_sb_cyc++;
        if (if_ready)  begin obs_if_rdy++;  t_if_rdy = cyc_no; saw_if_rdy = 1'b1; end
        if (mem_ready) begin obs_mem_rdy++; t_mem_rdy = cyc_no; end
    endtask

    // ---------------- requesters ----------------
    task automatic start_fetch(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
    endtask

    task automatic start_mem(input bit we, input bit byt, input logic [31:0] a, input logic [31:0] d);
        mem_req   = 1'b1;
        mem_we    = we;
        mem_byte  = byt;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 5))
            0:       return UART_DATA_ADDR;
            1:       return LED_ADDR;
            2:       return UART_STAT_ADDR;
            3:       return DPY_ADDR;
            default: return 32'h8000_0000 | ($urandom & 32'h003F_FFFC);
        endcase
    endfunction

    task automatic drive_next();
        if (e_if_rdy) if_req = 1'b0;
        if (e_mem_rdy) begin
            mem_req = 1'b0;
            if (mem_auto) start_mem(1'b0, 1'b0, 32'h8040_0000 | ($urandom & 32'hFFFC), '0);
        end
        if (rand_mode) begin
            if (!if_req && $urandom_range(0, 2) == 0)
                start_fetch(32'h8000_0000 | ($urandom & 32'h000F_FFFC));
            if (!mem_req && $urandom_range(0, 2) == 0)
                start_mem(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))), rand_addr(), $urandom);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc_no++;
        compare();
        drive_next();
    endtask

    task automatic wait_done(input int max_cyc);
        int n;
        n = 0;
        while ((if_req || mem_req || m_active) && n < max_cyc) begin
            step();
            n++;
        end
        check_eq("wait_bound", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_read"},   32'(mmu_read),  '0);
        check_eq({tag, "_write"},  32'(mmu_write), '0);
        check_eq({tag, "_addr"},   mmu_addr,  '0);
        check_eq({tag, "_wdata"},  mmu_wdata, '0);
        check_eq({tag, "_byte"},   32'(mmu_bytemode), '0);
        check_eq({tag, "_ifrdy"},  32'(if_ready),  '0);
        check_eq({tag, "_memrdy"}, 32'(mem_ready), '0);
        check_eq({tag, "_ifrd"},   if_rdata,  '0);
        check_eq({tag, "_memrd"},  mem_rdata, '0);
    endtask

    initial begin
        int t0, n;
        model_reset();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        check_eq("rst_stall", 32'(stall), '0);
        rst = 1'b0;

        // Single fetch: latency and strobe length
        obs_read_cyc = 0;
        t0 = cyc_no;
        start_fetch(32'h8000_0004);
        wait_done(40);
        check_eq("fetch_latency", 32'(t_if_rdy - t0), 32'(W + 2));
        check_eq("fetch_rd_cycles", 32'(obs_read_cyc), 32'(W + 1));
        check_eq("fetch_rdata", if_rdata, 32'h3C08_DEAD);

        // Contention: data first, fetch on the following idle
        t0 = cyc_no;
        start_fetch(32'h8000_0100);
        start_mem(1'b0, 1'b0, 32'h8040_0010, '0);
        wait_done(60);
        check_eq("data_first", 32'(t_mem_rdy < t_if_rdy), 32'd1);
        check_eq("contend_mem_lat", 32'(t_mem_rdy - t0), 32'(W + 2));
        check_eq("contend_if_lat",  32'(t_if_rdy - t0), 32'(2 * W + 5));

        // Reset in the middle of an access
        obs_if_rdy = 0;
        start_fetch(32'h8000_1000);
        step();
        step();
        #2;
        rst    = 1'b1;
        if_req = 1'b0;
        #1;
        check_all_zero("arst");
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_all_zero("arst_hold");
        rst = 1'b0;
        model_reset();
        repeat (W + 4) step();
        check_eq("no_ready_after_rst", 32'(obs_if_rdy), '0);

        // Streak limit: continuous data traffic with a waiting fetch
        for (int r = 0; r < 2; r++) begin
            mem_auto    = 1'b1;
            obs_mem_rdy = 0;
            saw_if_rdy  = 1'b0;
            if (!mem_req) start_mem(1'b0, 1'b0, 32'h8040_0100, '0);
            start_fetch(32'h8000_2000 + 32'(r * 4));
            n = 0;
            while (!saw_if_rdy && n < 200) begin
                step();
                n++;
            end
            check_eq("streak_bound", 32'(saw_if_rdy), 32'd1);
            check_eq("streak_grants", 32'(obs_mem_rdy), 32'(MAXS));
        end
        mem_auto = 1'b0;
        wait_done(60);

        // UART data read takes a single strobe cycle
        obs_read_cyc = 0;
        start_mem(1'b0, 1'b0, UART_DATA_ADDR, '0);
        wait_done(40);
        check_eq("uart_rd_cycles", 32'(obs_read_cyc), 32'd1);
        check_eq("uart_rdata", mem_rdata, 32'h41);

        // Byte store
        obs_write_cyc = 0;
        obs_sb_cyc    = 0;
        start_mem(1'b1, 1'b1, 32'h8000_0003, 32'h0000_00AB);
        wait_done(40);
        check_eq("sb_wr_cycles", 32'(obs_write_cyc), 32'(W + 1));
        check_eq("sb_fields",    32'(obs_sb_cyc),    32'(W + 1));
        check_eq("sb_rdata_kept", mem_rdata, 32'h41);

        // Random traffic
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        wait_done(200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
